sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Memory-side controller directly downstream of the MEM-stage load/store unit.
- Converts one 32-bit word request, with byte enables, into two 16-bit accesses on the external 256K x16 asynchronous SRAM. Each access lasts ACCESS_CYCLES cycles.
- Produces a stall to the hazard unit while the request is outstanding.
- Returns registered read data with a one-cycle acknowledge.

Parameters:
- ACCESS_CYCLES, 2, cycles per 16-bit SRAM access (legal range 2..15).
- SRAM_AW, 18, SRAM halfword address width.

Ports:
- i_clk  input  1  clock, rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_req  input  1  request valid; held stable by requester until o_ack
- i_wren  input  1  1 = write, 0 = read
- i_addr  input  19  byte address; bits [1:0] ignored (word aligned)
- i_bmask  input  4  byte enables, bit n = byte n of word
- i_wdata  input  32  store data
- o_rdata  output  32  load data, valid while o_ack=1
- o_ack  output  1  one-cycle completion pulse
- o_stall  output  1  combinational, i_req & ~o_ack; feeds hazard unit
- o_sram_addr  output  18  halfword address
- io_sram_dq  inout  16  SRAM data bus
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  output  1 each  SRAM active-low strobes

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, o_ack=0, o_rdata=0, o_sram_addr=0, all strobes=1, io_sram_dq=Z. A write in progress is abandoned; no completion is guaranteed.
- FSM states: IDLE, LO, HI, DONE. cnt is a 4-bit phase counter.
- IDLE, i_req=1 at edge k:
  - Latch wren, word address a=i_addr[18:2], bmask, wdata.
  - Write with bmask[1:0]=00: LO is skipped. Go to HI, or go straight to DONE if bmask=0000.
  - Read: always LO then HI; all bytes are read.
  - Otherwise go to LO.
- LO phase (halfword {a,0}):
  - o_sram_addr={a,1'b0}; ce_n=0.
  - lb_n=~bmask[0], ub_n=~bmask[1] for writes; 0 for reads.
  - Lasts ACCESS_CYCLES cycles, cnt 0..N-1.
  - Next state is HI, or DONE if a write has bmask[3:2]=00.
- HI phase (halfword {a,1}): same as LO, using bmask[3:2] and wdata[31:16].
- Write phase detail:
  - dq is driven with the selected half for the whole phase.
  - we_n=1 at cnt=0 (address setup), we_n=0 for cnt=1..N-1.
  - oe_n=1.
- Read phase detail:
  - oe_n=0, we_n=1, dq=Z.
  - At cnt=N-1, dq is sampled into o_rdata[15:0] (LO) or o_rdata[31:16] (HI).
- DONE:
  - o_ack=1 for exactly one cycle; strobes inactive; dq=Z.
  - Next state IDLE. i_req is ignored in DONE; a new request is accepted in IDLE at the following cycle.
- Latency, with request seen at edge k and N=ACCESS_CYCLES:
  - Full read/write: o_ack at cycle k+2N+1.
  - Single-half write: o_ack at k+N+1.
  - bmask=0000 write: o_ack at k+1.
- o_rdata holds its value after ack until the next read sample. Writes do not modify o_rdata.
- dq is never driven in IDLE, DONE or read phases; DONE provides bus turnaround.
- Changing i_req/i_addr mid-transaction has no effect; latched values are used.

Decomposition:
- Shared package sram_pkg:
  - state enum (IDLE, LO, HI, DONE)
  - SRAM_AW
  - SRAM_DW=16
  - strobe inactive constant
- No sub-module. The counter and tristate driver stay in the block.

Test Plan:
1. Write i_addr=0x00010, bmask=1111, wdata=0xDEADBEEF, N=2:
   - LO: addr 0x00008, dq=0xBEEF, lb_n=ub_n=0, we_n low only in the 2nd cycle.
   - HI: addr 0x00009, dq=0xDEAD.
   - o_ack at k+5.
   - o_stall=1 from k until ack.
2. Read i_addr=0x00010 with SRAM model holding 0x00008=0xBEEF, 0x00009=0xDEAD:
   - o_rdata=0xDEADBEEF with o_ack at k+5.
   - oe_n=0 during both phases; dq never driven by DUT.
3. Byte write bmask=0100, wdata=0x00AB0000:
   - Only HI phase at addr 0x00009, ub_n=1, lb_n=0, dq=0x00AB.
   - o_ack at k+3.
   - SRAM upper byte unchanged.
4. bmask=0000 write:
   - o_ack at k+1; ce_n, we_n stay 1.
5. Back-to-back: read then write, i_req dropped for one cycle after ack:
   - Second transaction starts in IDLE.
   - No overlapping dq drive; at least one Z cycle between read sample and write drive.
6. Assert i_rstn=0 mid-LO of a write:
   - All strobes 1, dq=Z, o_ack=0, o_rdata=0 immediately (async).
   - After release, state=IDLE and a new read completes normally.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit to 2x16-bit asynchronous SRAM controller.
`default_nettype none

package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic lb_n;
        logic ub_n;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1};

endpackage

`default_nettype wire

// File: rtl/sram_ctrl.sv
// Splits a 32-bit word request into LO/HI halfword accesses on an async 256Kx16 SRAM,
// stalling the pipeline until a one-cycle acknowledge with registered read data.
`default_nettype none

module sram_ctrl #(
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_AW       = sram_pkg::SRAM_AW
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_req,
    input  logic                        i_wren,
    input  logic [SRAM_AW:0]            i_addr,
    input  logic [3:0]                  i_bmask,
    input  logic [31:0]                 i_wdata,
    output logic [31:0]                 o_rdata,
    output logic                        o_ack,
    output logic                        o_stall,
    output logic [SRAM_AW-1:0]          o_sram_addr,
    inout  wire  [sram_pkg::SRAM_DW-1:0] io_sram_dq,
    output logic                        o_sram_ce_n,
    output logic                        o_sram_oe_n,
    output logic                        o_sram_we_n,
    output logic                        o_sram_lb_n,
    output logic                        o_sram_ub_n
);
    import sram_pkg::*;

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wren_q, wren_d;
    logic [SRAM_AW-2:0]  waddr_q, waddr_d;
    logic [3:0]          bmask_q, bmask_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    strobes_t            strb;
    logic                dq_oe;
    logic [SRAM_DW-1:0]  dq_out;
    logic [1:0]          half_mask;
    logic                is_hi;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            bmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            waddr_q <= waddr_d;
            bmask_q <= bmask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wren_d  = wren_q;
        waddr_d = waddr_q;
        bmask_d = bmask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    wren_d  = i_wren;
                    waddr_d = i_addr[SRAM_AW:2];
                    bmask_d = i_bmask;
                    wdata_d = i_wdata;
                    cnt_d   = '0;
                    // Writes that touch no low byte go straight to HI (or finish at once).
                    if (i_wren && i_bmask[1:0] == 2'b00)
                        state_d = (i_bmask[3:2] == 2'b00) ? ST_DONE : ST_HI;
                    else
                        state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!wren_q)
                        rdata_d[15:0] = io_sram_dq;
                    state_d = (wren_q && bmask_q[3:2] == 2'b00) ? ST_DONE : ST_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HI: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!wren_q)
                        rdata_d[31:16] = io_sram_dq;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        strb      = STROBES_IDLE;
        dq_oe     = 1'b0;
        is_hi     = (state_q == ST_HI);
        half_mask = is_hi ? bmask_q[3:2] : bmask_q[1:0];
        dq_out    = is_hi ? wdata_q[31:16] : wdata_q[15:0];
        if (state_q == ST_LO || state_q == ST_HI) begin
            strb.ce_n = 1'b0;
            if (wren_q) begin
                // First cycle of each write phase is address setup with WE# high.
                strb.we_n = (cnt_q == 4'd0);
                strb.lb_n = ~half_mask[0];
                strb.ub_n = ~half_mask[1];
                dq_oe     = 1'b1;
            end else begin
                strb.oe_n = 1'b0;
                strb.lb_n = 1'b0;
                strb.ub_n = 1'b0;
            end
        end
    end

    assign io_sram_dq  = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign o_sram_addr = {waddr_q, is_hi};
    assign o_sram_ce_n = strb.ce_n;
    assign o_sram_oe_n = strb.oe_n;
    assign o_sram_we_n = strb.we_n;
    assign o_sram_lb_n = strb.lb_n;
    assign o_sram_ub_n = strb.ub_n;
    assign o_ack       = (state_q == ST_DONE);
    assign o_stall     = i_req & ~o_ack;
    assign o_rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl.sv
// Self-checking bench: behavioural SRAM plus a timeline/reference model of each transaction.
`default_nettype none

module tb_sram_ctrl;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic        wren = 1'b0;
    logic [18:0] addr = '0;
    logic [3:0]  bmask = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, stall;
    logic [17:0] sram_addr;
    wire  [15:0] dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;

    int n_checks = 0;
    int n_fail   = 0;

    bit [15:0] mem     [262144];
    bit [15:0] exp_mem [262144];

    sram_ctrl #(.ACCESS_CYCLES(N), .SRAM_AW(18)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_wren(wren), .i_addr(addr),
        .i_bmask(bmask), .i_wdata(wdata), .o_rdata(rdata), .o_ack(ack), .o_stall(stall),
        .o_sram_addr(sram_addr), .io_sram_dq(dq), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
        .o_sram_we_n(we_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    always #5 clk = ~clk;

    assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr][7:0]  = dq[7:0];
            if (!ub_n) mem[sram_addr][15:8] = dq[15:8];
        end
    end

    // One transaction against a cycle-by-cycle timeline derived from the access rules.
    task automatic run_txn(input logic wr, input logic [18:0] a, input logic [3:0] bm,
                           input logic [31:0] wd, input string name);
        int  nh, d, slot, c;
        logic hsel [2];
        logic h;
        logic [1:0]  hm;
        logic [4:0]  exp_strb, act_strb;
        logic [17:0] exp_addr;
        logic [31:0] exp_rd;
        nh = 0;
        if (wr) begin
            if (bm[1:0] != 2'b00) begin hsel[nh] = 1'b0; nh++; end
            if (bm[3:2] != 2'b00) begin hsel[nh] = 1'b1; nh++; end
        end else begin
            hsel[0] = 1'b0; hsel[1] = 1'b1; nh = 2;
        end
        d = nh * N + 1;
        exp_rd = {exp_mem[{a[18:2], 1'b1}], exp_mem[{a[18:2], 1'b0}]};

        @(negedge clk);
        req = 1'b1; wren = wr; addr = a; bmask = bm; wdata = wd;
        @(posedge clk);
        for (int j = 1; j <= d; j++) begin
            @(negedge clk);
            // Disturb request inputs mid-transaction; latched values must be used.
            addr = 19'(~a); wdata = ~wd; bmask = ~bm;
            act_strb = {ce_n, oe_n, we_n, lb_n, ub_n};
            if (j == d) begin
                n_checks++;
                if (ack !== 1'b1) begin n_fail++; $display("FAIL %s ack: got %b want 1 at cycle %0d", name, ack, j); end
                n_checks++;
                if (stall !== 1'b0) begin n_fail++; $display("FAIL %s stall_at_ack: got %b want 0", name, stall); end
                n_checks++;
                if (act_strb !== 5'b11111) begin n_fail++; $display("FAIL %s done_strobes: got %b want 11111", name, act_strb); end
                if (!wr) begin
                    n_checks++;
                    if (rdata !== exp_rd) begin n_fail++; $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rd); end
                end
                req = 1'b0;
            end else begin
                slot = (j - 1) / N;
                c    = (j - 1) % N;
                h    = hsel[slot];
                hm   = h ? bm[3:2] : bm[1:0];
                exp_addr = {a[18:2], h};
                exp_strb = wr ? {1'b0, 1'b1, (c == 0), ~hm[0], ~hm[1]} : 5'b00100;
                n_checks++;
                if (ack !== 1'b0 || stall !== 1'b1) begin
                    n_fail++; $display("FAIL %s ack_stall: got ack=%b stall=%b want ack=0 stall=1 cycle %0d", name, ack, stall, j);
                end
                n_checks++;
                if (act_strb !== exp_strb) begin n_fail++; $display("FAIL %s strobes: got %b want %b cycle %0d", name, act_strb, exp_strb, j); end
                n_checks++;
                if (sram_addr !== exp_addr) begin n_fail++; $display("FAIL %s sram_addr: got %h want %h cycle %0d", name, sram_addr, exp_addr, j); end
                n_checks++;
                if (wr && dq !== (h ? wd[31:16] : wd[15:0])) begin
                    n_fail++; $display("FAIL %s wr_dq: got %h want %h cycle %0d", name, dq, h ? wd[31:16] : wd[15:0], j);
                end else if (!wr && dq !== exp_mem[exp_addr]) begin
                    n_fail++; $display("FAIL %s rd_dq: got %h want %h cycle %0d", name, dq, exp_mem[exp_addr], j);
                end
            end
        end
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (bm[b]) exp_mem[{a[18:2], 1'(b / 2)}][(b % 2) * 8 +: 8] = wd[b * 8 +: 8];
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin n_fail++; $display("FAIL reset_strobes: got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); end
        n_checks++;
        if (ack !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got ack=%b stall=%b want 0 0", ack, stall); end
        n_checks++;
        if (rdata !== 32'h0 || sram_addr !== 18'h0) begin n_fail++; $display("FAIL reset_regs: got rdata=%h addr=%h want 0 0", rdata, sram_addr); end
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_full_write();  run_txn(1'b1, 19'h00010, 4'b1111, 32'hDEADBEEF, "full_write"); endtask
    task automatic test_full_read();   run_txn(1'b0, 19'h00010, 4'b0000, 32'h0, "full_read"); endtask

    task automatic test_byte_write();
        run_txn(1'b1, 19'h00010, 4'b0100, 32'h00AB0000, "byte_write");
        run_txn(1'b0, 19'h00010, 4'b1111, 32'h0, "byte_readback");
    endtask

    task automatic test_zero_mask();
        run_txn(1'b1, 19'h00020, 4'b0000, 32'h12345678, "zero_mask");
        run_txn(1'b0, 19'h00020, 4'b1111, 32'h0, "zero_mask_readback");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 19'h00010, 4'b1111, 32'h0, "b2b_read");
        run_txn(1'b1, 19'h00014, 4'b0011, 32'hCAFE5A5A, "b2b_write");
        run_txn(1'b0, 19'h00014, 4'b1111, 32'h0, "b2b_readback");
    endtask

    task automatic test_random();
        logic [18:0] a;
        for (int i = 0; i < 24; i++) begin
            a = {12'h0, 3'($urandom_range(0, 7)), 4'h0} | 19'h00100;
            a[3:2] = 2'($urandom);
            a[1:0] = 2'($urandom);
            run_txn(1'($urandom), a, 4'($urandom), $urandom, "random");
        end
    endtask

    task automatic test_async_reset();
        run_txn(1'b0, 19'h00010, 4'b1111, 32'h0, "pre_reset_read");
        @(negedge clk);
        req = 1'b1; wren = 1'b1; addr = 19'h00040; bmask = 4'hF; wdata = 32'h11112222;
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        n_checks++;
        if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin n_fail++; $display("FAIL async_rst_strobes: got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); end
        n_checks++;
        if (ack !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL async_rst_regs: got ack=%b rdata=%h want 0 0", ack, rdata); end
        req = 1'b0;
        @(negedge clk); rstn = 1'b1;
        run_txn(1'b0, 19'h00010, 4'b1111, 32'h0, "post_reset_read");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_write();
        test_full_read();
        test_byte_write();
        test_zero_mask();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
